// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and small bit-level helpers for the UART receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // data_xor is the XOR of all received data bits; returns 1 when the parity bit disagrees.
  function automatic logic parity_error(input logic data_xor, input logic par_bit, input int mode);
    logic err;
    case (mode)
      PAR_ODD:  err = ~(data_xor ^ par_bit);
      PAR_EVEN: err = data_xor ^ par_bit;
      default:  err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a majority vote over the
// current synchronized sample and the two before it.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_s_o,
  output logic maj_o
);

  logic [1:0] sync_q;
  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      hist_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      hist_q <= {hist_q[0], sync_q[1]};
    end
  end

  assign rx_s_o = sync_q[1];
  assign maj_o  = majority3(sync_q[1], hist_q[0], hist_q[1]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Parameterised UART receiver: start/data/parity/stop framing with majority
// sampling at mid-bit, error/break flags and a one-cycle done pulse.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 rx_done_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 break_o,
  output logic                 busy_o
);

  localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  logic                 rx_s;
  logic                 maj_s;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 sample_s;
  logic                 wrap_s;
  rx_state_e            state_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 any_one_q;
  logic                 stop_err_q;
  logic                 perr_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 done_q;
  logic                 perr_out_q;
  logic                 ferr_q;
  logic                 brk_q;
  logic                 busy_q;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_i   (rx_i),
    .rx_s_o (rx_s),
    .maj_o  (maj_s)
  );

  // The sample edge is the one on which the counter steps onto the mid-bit value.
  always_comb begin
    wrap_s = (cnt_q == CNT_LAST);
    if (wrap_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    sample_s = (cnt_d == CNT_HALF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= 4'd0;
      shift_q    <= '0;
      any_one_q  <= 1'b0;
      stop_err_q <= 1'b0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cnt_q  <= cnt_d;
      case (state_q)
        ST_IDLE: begin
          cnt_q      <= '0;
          bit_q      <= 4'd0;
          any_one_q  <= 1'b0;
          stop_err_q <= 1'b0;
          perr_q     <= 1'b0;
          if (!rx_s) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (sample_s && maj_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (wrap_s) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (sample_s) begin
            shift_q   <= {maj_s, shift_q[DATA_BITS-1:1]};
            any_one_q <= any_one_q | maj_s;
          end
          if (wrap_s) begin
            if (bit_q == DATA_LAST) begin
              bit_q   <= 4'd0;
              state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (sample_s) begin
            perr_q    <= parity_error(^shift_q, maj_s, PARITY);
            any_one_q <= any_one_q | maj_s;
          end
          if (wrap_s) begin
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Leave at the last stop sample so a following start bit is not missed.
          if (sample_s && (bit_q == STOP_LAST)) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            data_q     <= shift_q;
            perr_out_q <= perr_q;
            ferr_q     <= stop_err_q | ~maj_s;
            brk_q      <= ~(any_one_q | maj_s);
          end else if (sample_s) begin
            stop_err_q <= stop_err_q | ~maj_s;
            any_one_q  <= any_one_q | maj_s;
          end else if (wrap_s) begin
            bit_q <= bit_q + 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_o       = data_q;
  assign rx_done_o    = done_q;
  assign parity_err_o = perr_out_q;
  assign frame_err_o  = ferr_q;
  assign break_o      = brk_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three instances (default, even parity, two stop bits).
module tb_uart_rx_cfg;

  localparam int C = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_a, rx_b, rx_c;
  logic [7:0] data_a, data_b, data_c;
  logic done_a, done_b, done_c;
  logic pe_a, pe_b, pe_c;
  logic fe_a, fe_b, fe_c;
  logic br_a, br_b, br_c;
  logic busy_a, busy_b, busy_c;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       br;
    int         cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_def (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_a), .data_o(data_a), .rx_done_o(done_a),
    .parity_err_o(pe_a), .frame_err_o(fe_a), .break_o(br_a), .busy_o(busy_a));

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_par (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_b), .data_o(data_b), .rx_done_o(done_b),
    .parity_err_o(pe_b), .frame_err_o(fe_b), .break_o(br_b), .busy_o(busy_b));

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_stp (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_c), .data_o(data_c), .rx_done_o(done_c),
    .parity_err_o(pe_c), .frame_err_o(fe_c), .break_o(br_c), .busy_o(busy_c));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input int k, input logic v);
    case (k)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Drives one frame starting just after a clock edge; optionally queues the expected result.
  task automatic frame(input int k, input logic [7:0] d, input logic par_en, input logic par_bit,
                       input int nstop, input logic stop_v, input logic expect_v,
                       input logic pe, input logic fe, input logic br);
    logic [11:0] bits;
    int nb;
    int t0;
    exp_t e;
    bits    = 12'hFFF;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    nb = 9;
    if (par_en) begin
      bits[nb] = par_bit;
      nb++;
    end
    for (int s = 0; s < nstop; s++) begin
      bits[nb] = stop_v;
      nb++;
    end
    t0 = cyc + 1;
    if (expect_v) begin
      e.data = d;
      e.pe   = pe;
      e.fe   = fe;
      e.br   = br;
      e.cyc  = t0 + 2 + (nb - 1) * C + C / 2;
      case (k)
        0:       q_a.push_back(e);
        1:       q_b.push_back(e);
        default: q_c.push_back(e);
      endcase
    end
    for (int i = 0; i < nb; i++) begin
      set_rx(k, bits[i]);
      idle(C);
    end
    set_rx(k, 1'b1);
  endtask

  task automatic mon(input int k, input logic done, input logic [7:0] d,
                     input logic pe, input logic fe, input logic br);
    exp_t e;
    int n;
    if (done === 1'b1) begin
      case (k)
        0:       n = q_a.size();
        1:       n = q_b.size();
        default: n = q_c.size();
      endcase
      if (n == 0) begin
        checks++;
        errors++;
        $display("FAIL dut%0d_unexpected_pulse: got pulse data %0h at cycle %0d, required no pulse", k, d, cyc);
      end else begin
        case (k)
          0:       e = q_a.pop_front();
          1:       e = q_b.pop_front();
          default: e = q_c.pop_front();
        endcase
        chk($sformatf("dut%0d_cycle", k), cyc, e.cyc);
        chk($sformatf("dut%0d_data", k), {24'd0, d}, {24'd0, e.data});
        chk($sformatf("dut%0d_flags(pe,fe,br)", k), {29'd0, pe, fe, br}, {29'd0, e.pe, e.fe, e.br});
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, done_a, data_a, pe_a, fe_a, br_a);
    mon(1, done_b, data_b, pe_b, fe_b, br_b);
    mon(2, done_c, data_c, pe_c, fe_c, br_c);
  end

  initial begin
    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    rx_c  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", {24'd0, data_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_flags", {29'd0, pe_a, fe_a, br_a}, 32'd0);
    chk("rst_busy", {29'd0, busy_a, busy_b, busy_c}, 32'd0);
    rst_n = 1'b1;
    idle(5);

    frame(0, 8'h55, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);

    set_rx(0, 1'b0);
    idle(3);
    set_rx(0, 1'b1);
    idle(2);
    chk("glitch_busy_high", {31'd0, busy_a}, 32'd1);
    idle(10);
    chk("glitch_busy_low", {31'd0, busy_a}, 32'd0);
    chk("glitch_data_kept", {24'd0, data_a}, 32'h55);
    chk("glitch_flags_kept", {29'd0, pe_a, fe_a, br_a}, 32'd0);

    frame(0, 8'h12, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(20);
    frame(0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(20);
    chk("break_busy_low", {31'd0, busy_a}, 32'd0);

    frame(1, 8'hA5, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(20);
    frame(1, 8'hA5, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);

    frame(2, 8'h3C, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(2, 8'hC3, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);

    fork
      frame(0, 8'hF8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      begin
        idle(4 * C + 3);
        chk("midframe_busy", {31'd0, busy_a}, 32'd1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("midrst_data", {24'd0, data_a}, 32'd0);
        chk("midrst_flags", {29'd0, pe_a, fe_a, br_a}, 32'd0);
        chk("midrst_busy", {31'd0, busy_a}, 32'd0);
        chk("midrst_data_par", {24'd0, data_b}, 32'd0);
      end
    join
    idle(20);
    frame(0, 8'h81, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(30);

    chk("pending_a", q_a.size(), 32'd0);
    chk("pending_b", q_b.size(), 32'd0);
    chk("pending_c", q_c.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
